mux_rr_sched: RTL and testbench

Round-robin scheduler that shares one keyed-mux output channel among `NR_REQ` valid/ready requesters. It selects one requester at a time and steers that requester's data through the select mux into a registered output stage. A grant covers a burst of up to `MAX_BURST` beats. The block sits in front of any consumer that previously took a fixed 4:1 2-bit mux output, and replaces the static select with arbitrated, flow-controlled access.

---
 rtl/mux_sched_pkg.sv | 28 ++
 rtl/MuxKey.sv | 26 ++
 rtl/mux_rr_sched_rr_pick.sv | 43 ++++
 rtl/mux_rr_sched.sv | 130 +++++++++++++
 tb/tb_mux_rr_sched.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mux_sched_pkg.sv
// Shared definitions for the round-robin mux scheduler slice.
//   - sched_state_t : scheduler FSM states
//   - idx_width()   : requester index width for a given requester count
//   - cnt_width()   : burst beat counter width for a given burst limit
//   - *_DEF         : default parameter values used across the slice
package mux_sched_pkg;

  localparam int unsigned NR_REQ_DEF    = 4;
  localparam int unsigned DATA_LEN_DEF  = 2;
  localparam int unsigned MAX_BURST_DEF = 4;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } sched_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned b);
    return $clog2(b + 1);
  endfunction

  localparam int unsigned IDX_W_DEF = idx_width(NR_REQ_DEF);
  localparam int unsigned CNT_W_DEF = cnt_width(MAX_BURST_DEF);

endpackage

// File: rtl/MuxKey.sv
// Keyed multiplexer library cell.
//   key : select key
//   lut : NR_KEY packed {key, data} pairs, pair i at [i*(KEY_LEN+DATA_LEN) +: KEY_LEN+DATA_LEN]
//   out : data of the matching pair, zero when no key matches
module MuxKey #(
  parameter int unsigned NR_KEY   = 2,
  parameter int unsigned KEY_LEN  = 1,
  parameter int unsigned DATA_LEN = 1
) (
  output logic [DATA_LEN-1:0]                  out,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);

  localparam int unsigned PAIR_W = KEY_LEN + DATA_LEN;

  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < NR_KEY; i++) begin
      if (lut[i*PAIR_W+DATA_LEN +: KEY_LEN] == key) begin
        out = lut[i*PAIR_W +: DATA_LEN];
      end
    end
  end

endmodule

// File: rtl/mux_rr_sched_rr_pick.sv
// Combinational round-robin picker.
//   req  : request vector
//   last : most recently served index (lowest priority)
//   any  : at least one request is set
//   idx  : first set request scanning last+1, last+2, ... modulo NR_REQ
module rr_pick
  import mux_sched_pkg::*;
#(
  parameter int unsigned NR_REQ = NR_REQ_DEF
) (
  input  logic [NR_REQ-1:0]              req,
  input  logic [idx_width(NR_REQ)-1:0]   last,
  output logic                           any,
  output logic [idx_width(NR_REQ)-1:0]   idx
);

  localparam int unsigned IDX_W = idx_width(NR_REQ);

  logic [2*NR_REQ-1:0] dbl;
  logic [NR_REQ-1:0]   rot;
  logic [IDX_W-1:0]    base;
  logic [IDX_W-1:0]    off;
  logic                found;

  // Rotate so that last+1 lands at bit 0, priority-encode from bit 0, then
  // add the rotation back; NR_REQ is a power of two so the add wraps cleanly.
  always_comb begin
    base  = last + IDX_W'(1);
    dbl   = {req, req};
    rot   = dbl[base +: NR_REQ];
    off   = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < NR_REQ; j++) begin
      if (rot[j] && !found) begin
        off   = IDX_W'(j);
        found = 1'b1;
      end
    end
    any = found;
    idx = base + off;
  end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing one registered keyed-mux output among
// NR_REQ valid/ready requesters, granting bursts of up to MAX_BURST beats.
//   clk, rst  : clock, synchronous active-high reset
//   req_valid : per-requester beat available
//   req_data  : per-requester payload, requester i at [DATA_LEN*i +: DATA_LEN]
//   req_ready : one-hot (or zero) acceptance for the current grantee
//   out_valid : output register holds a beat
//   out_data  : beat payload
//   out_sel   : requester index that produced out_data
//   out_ready : consumer accepts the beat when out_valid && out_ready
module mux_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int unsigned NR_REQ    = NR_REQ_DEF,
  parameter int unsigned DATA_LEN  = DATA_LEN_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NR_REQ-1:0]              req_valid,
  input  logic [NR_REQ*DATA_LEN-1:0]     req_data,
  output logic [NR_REQ-1:0]              req_ready,
  output logic                           out_valid,
  output logic [DATA_LEN-1:0]            out_data,
  output logic [idx_width(NR_REQ)-1:0]   out_sel,
  input  logic                           out_ready
);

  localparam int unsigned IDX_W  = idx_width(NR_REQ);
  localparam int unsigned CNT_W  = cnt_width(MAX_BURST);
  localparam int unsigned PAIR_W = IDX_W + DATA_LEN;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NR_REQ - 1);

  sched_state_t               state;
  logic [IDX_W-1:0]           sel;
  logic [IDX_W-1:0]           last;
  logic [CNT_W-1:0]           beat_cnt;

  logic                       pick_any;
  logic [IDX_W-1:0]           pick_idx;
  logic [DATA_LEN-1:0]        sel_data;
  logic [NR_REQ*PAIR_W-1:0]   lut;

  logic                       sel_valid;
  logic                       can_accept;
  logic                       xfer;
  logic                       rel;

  rr_pick #(
    .NR_REQ (NR_REQ)
  ) u_pick (
    .req  (req_valid),
    .last (last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    lut = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      lut[i*PAIR_W +: PAIR_W] = {IDX_W'(i), req_data[i*DATA_LEN +: DATA_LEN]};
    end
  end

  MuxKey #(
    .NR_KEY   (NR_REQ),
    .KEY_LEN  (IDX_W),
    .DATA_LEN (DATA_LEN)
  ) u_mux (
    .out (sel_data),
    .key (sel),
    .lut (lut)
  );

  // No skid buffer: the grantee may push only when the output register is
  // empty or being drained this cycle.
  always_comb begin
    sel_valid  = req_valid[sel];
    can_accept = !out_valid || out_ready;
    req_ready  = '0;
    if (state == S_GRANT) begin
      req_ready[sel] = can_accept;
    end
    xfer = (state == S_GRANT) && sel_valid && can_accept;
    rel  = (state == S_GRANT) && (!sel_valid || (xfer && (beat_cnt == LAST_BEAT)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sel       <= '0;
      last      <= LAST_INIT;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pick_any) begin
            sel      <= pick_idx;
            beat_cnt <= '0;
            state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (xfer) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
          if (rel) begin
            last  <= sel;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_sched.sv
module tb_mux_rr_sched;

  localparam int N  = 4;
  localparam int D  = 2;
  localparam int MB = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*D-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic [D-1:0]     out_data;
  logic [IW-1:0]    out_sel;
  logic             out_ready;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // behavioural model: a grant is "who", counted in beats, released to "last"
  bit  m_grant;
  int  m_who, m_beats, m_last;
  bit  m_ov;
  int  m_od, m_os;

  int          seen_sel[$];
  int          seen_dat[$];
  bit          ov_hist[$];
  int unsigned acc_cnt;

  always #5 clk = ~clk;

  mux_rr_sched #(
    .NR_REQ    (N),
    .DATA_LEN  (D),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    m_grant = 0; m_who = 0; m_beats = 0; m_last = N - 1;
    m_ov = 0; m_od = 0; m_os = 0;
  endfunction

  // One clock: check DUT against model before the edge, advance the model, step.
  task automatic cycle();
    logic [N-1:0]   er;
    logic [N*D-1:0] sh;
    bit             x;
    #1;
    er = '0;
    if (m_grant && (!m_ov || out_ready)) er = N'(1 << m_who);
    chk("req_ready", req_ready, er);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("out_sel", out_sel, m_os);
    ov_hist.push_back(out_valid);
    if (out_valid && out_ready) begin
      seen_sel.push_back(int'(out_sel));
      seen_dat.push_back(int'(out_data));
    end
    if ((req_valid & req_ready) != '0) acc_cnt++;
    if (rst) begin
      model_reset();
    end else begin
      x = (er != '0) && req_valid[m_who];
      sh = req_data >> (D * m_who);
      if (x) begin
        m_ov = 1; m_od = int'(sh[D-1:0]); m_os = m_who;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (!m_grant) begin
        for (int k = 1; k <= N; k++) begin
          if (!m_grant && req_valid[(m_last + k) % N]) begin
            m_grant = 1; m_who = (m_last + k) % N; m_beats = 0;
          end
        end
      end else begin
        if (x) m_beats++;
        if (!req_valid[m_who] || m_beats == MB) begin
          m_grant = 0; m_last = m_who;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_hist();
    seen_sel.delete(); seen_dat.delete(); ov_hist.delete(); acc_cnt = 0;
  endtask

  initial begin
    logic [D-1:0] held;
    model_reset();
    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;
    @(negedge clk);

    // reset defaults with everyone requesting; requester i drives data i
    req_valid = 4'b1111;
    req_data  = {2'd3, 2'd2, 2'd1, 2'd0};
    cycle(); cycle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b0;
    clear_hist();
    repeat (24) cycle();
    chk("rr_beats", (seen_sel.size() >= 16), 1);
    for (int k = 0; k < 16 && k < seen_sel.size(); k++) begin
      chk("rr_sel", seen_sel[k], k / 4);
      chk("rr_data", seen_dat[k], k / 4);
    end

    // single requester burst: 4 beats, 1 bubble, regrant to the same requester
    rst = 1'b1; cycle(); rst = 1'b0;
    req_valid = 4'b0100;
    req_data  = 8'b10_10_10_10;
    clear_hist();
    repeat (14) cycle();
    for (int k = 0; k < 14; k++) begin
      chk("burst_ov", ov_hist[k], (k >= 2) && (((k - 2) % 5) != 4));
    end
    for (int k = 0; k < seen_sel.size(); k++) begin
      chk("burst_sel", seen_sel[k], 2);
      chk("burst_data", seen_dat[k], 2);
    end

    // back-pressure for 3 cycles mid-burst; burst still totals MAX_BURST beats
    rst = 1'b1; cycle(); rst = 1'b0;
    req_valid = 4'b0001;
    req_data  = 8'b00_00_00_01;
    clear_hist();
    cycle(); cycle(); cycle();
    out_ready = 1'b0;
    held = out_data;
    cycle(); cycle(); cycle();
    chk("bp_hold_data", out_data, held);
    chk("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    cycle(); cycle(); cycle();
    chk("bp_total_beats", acc_cnt, MB);

    // early drop of requester 1 with 3 pending: next grant goes to 3
    rst = 1'b1; cycle(); rst = 1'b0;
    req_valid = 4'b1010;
    req_data  = {2'b11, 2'b00, 2'b01, 2'b00};
    clear_hist();
    cycle(); cycle(); cycle();
    req_valid = 4'b1000;
    repeat (4) cycle();
    chk("drop_beats", (seen_sel.size() >= 3), 1);
    if (seen_sel.size() >= 3) begin
      chk("drop_first", seen_sel[0], 1);
      chk("drop_second", seen_sel[1], 1);
      chk("drop_next", seen_sel[2], 3);
      chk("drop_next_data", seen_dat[2], 3);
    end
    // reset mid-burst discards the held beat
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) req_valid = N'($urandom_range(0, 15));
      req_data  = N*D'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
